// File: rtl/ss_scan_ctrl.sv
// ss_scan_ctrl: multiplexed seven-segment scan with blanking gaps, leading-zero blanking and frame-synchronous double buffering
module ss_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [3:0]              digit_bcd,
  output logic                    dp_n,
  output logic                    frame_done
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [4*NUM_DIGITS-1:0] act, act_d, sh, sh_d;
  logic [NUM_DIGITS-1:0] act_dp, act_dp_d, sh_dp, sh_dp_d, an_d;
  logic pending, pending_d, frame_end, apply, lz, dpn_d, fd_d;
  logic [3:0] bcd_d;
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    cnt_d     = cnt + 1'b1;
    act_d     = act;
    act_dp_d  = act_dp;
    sh_d      = sh;
    sh_dp_d   = sh_dp;
    pending_d = pending;
    frame_end = state == SHOW && cnt == CW'(REFRESH_DIV - 1) && idx == LAST && enable;
    apply     = frame_end || (state != IDLE && !enable);
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state == IDLE) begin
      state_d = BLANK;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state == BLANK && cnt == CW'(BLANK_CYC - 1)) begin
      state_d = SHOW;
    end else if (state == SHOW && cnt == CW'(REFRESH_DIV - 1)) begin
      state_d = BLANK;
      cnt_d   = '0;
      idx_d   = idx == LAST ? '0 : idx + 1'b1;
    end
    // a load landing on the swap cycle is newer than the shadow, so it wins
    if (load && (state == IDLE || apply)) begin
      act_d     = value_in;
      act_dp_d  = dp_in;
      pending_d = 1'b0;
    end else if (load) begin
      sh_d      = value_in;
      sh_dp_d   = dp_in;
      pending_d = 1'b1;
    end else if (apply && pending) begin
      act_d     = sh;
      act_dp_d  = sh_dp;
      pending_d = 1'b0;
    end
    lz = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (i >= int'(idx_d) && act_d[4*i +: 4] != 4'h0) lz = 1'b0;
    // outputs are registered from next-state values so they line up with the state they describe
    bcd_d = state_d == IDLE ? 4'hF : (lz_blank_en && idx_d != '0 && lz) ? 4'hF : act_d[4*idx_d +: 4];
    an_d  = state_d == SHOW ? ~(NUM_DIGITS'(1) << idx_d) : '1;
    dpn_d = state_d == IDLE || !act_dp_d[idx_d];
    fd_d  = state_d == SHOW && idx_d == LAST && cnt_d == CW'(REFRESH_DIV - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      act        <= '0;
      act_dp     <= '0;
      sh         <= '0;
      sh_dp      <= '0;
      pending    <= 1'b0;
      an         <= '1;
      digit_bcd  <= 4'hF;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      act        <= act_d;
      act_dp     <= act_dp_d;
      sh         <= sh_d;
      sh_dp      <= sh_dp_d;
      pending    <= pending_d;
      an         <= an_d;
      digit_bcd  <= bcd_d;
      dp_n       <= dpn_d;
      frame_done <= fd_d;
    end
  end
endmodule

// File: tb/tb_ss_scan_ctrl.sv
// tb_ss_scan_ctrl: directed and random scan checks against a time-position model of the display
module tb_ss_scan_ctrl;
  localparam int N = 4, RD = 8, BC = 2, FR = N * RD;
  logic clk = 0, rst_n = 0, enable = 0, load = 0, lz_blank_en = 0;
  logic [15:0] value_in = '0;
  logic [3:0] dp_in = '0;
  logic [3:0] an, digit_bcd;
  logic dp_n, frame_done;
  int checks = 0, errors = 0;
  bit m_run, m_pend;
  int m_t;
  logic [15:0] m_act, m_sh;
  logic [3:0] m_adp, m_sdp;
  logic [3:0] e_an, e_bcd;
  logic e_dp, e_fd;

  always #5 clk = ~clk;

  ss_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value_in(value_in),
    .dp_in(dp_in), .lz_blank_en(lz_blank_en), .an(an), .digit_bcd(digit_bcd),
    .dp_n(dp_n), .frame_done(frame_done)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, m_t);
    end
  endtask

  // expected outputs follow from where the scan sits in time: slot = t/RD, blank while t%RD < BC
  task automatic set_exp();
    int d;
    d = (m_t / RD) % N;
    if (!m_run) begin
      e_an = 4'hF; e_bcd = 4'hF; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      e_an  = (m_t % RD >= BC) ? ~(4'b0001 << d) : 4'hF;
      e_bcd = (lz_blank_en && d > 0 && (m_act >> (4 * d)) == 16'h0) ? 4'hF : 4'(m_act >> (4 * d));
      e_dp  = ~m_adp[d];
      e_fd  = (m_t % FR) == FR - 1;
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_t = 0; m_act = '0; m_sh = '0; m_adp = '0; m_sdp = '0; m_pend = 0;
    set_exp();
  endtask

  task automatic model_step();
    bit apply;
    if (!rst_n) begin
      model_reset();
      return;
    end
    apply = m_run && (!enable || (m_t % FR) == FR - 1);
    if (load && (!m_run || apply)) begin
      m_act = value_in; m_adp = dp_in; m_pend = 0;
    end else if (load) begin
      m_sh = value_in; m_sdp = dp_in; m_pend = 1;
    end else if (apply && m_pend) begin
      m_act = m_sh; m_adp = m_sdp; m_pend = 0;
    end
    if (!enable) begin
      m_run = 0; m_t = 0;
    end else if (!m_run) begin
      m_run = 1; m_t = 0;
    end else m_t++;
    set_exp();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("an", an, e_an);
    check("digit_bcd", digit_bcd, e_bcd);
    check("dp_n", dp_n, e_dp);
    check("frame_done", frame_done, e_fd);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(int target);
    int n = 0;
    while (!(m_run && (m_t % FR) == target) && n < 200) begin
      tick();
      n++;
    end
    check("run_to_reached", n < 200, 1);
  endtask

  task automatic pulse_load(logic [15:0] v, logic [3:0] dp);
    load = 1; value_in = v; dp_in = dp;
    tick();
    load = 0;
  endtask

  initial begin
    model_reset();
    run(2);
    rst_n = 1;
    run(3);
    pulse_load(16'h1234, 4'b0000);
    enable = 1;
    check("start_bcd_pre", digit_bcd, 4'hF);
    tick();
    check("digit0_blank_bcd", digit_bcd, 4'h4);
    run(64);
    run_to(9);
    pulse_load(16'h5678, 4'b0000);
    run(40);
    run_to(15);
    pulse_load(16'h9999, 4'b0000);
    run_to(31);
    check("collision_frame_done", frame_done, 1);
    pulse_load(16'h4321, 4'b0000);
    check("collision_digit0", digit_bcd, 4'h1);
    run(40);
    lz_blank_en = 1;
    pulse_load(16'h0050, 4'b0000);
    run(70);
    pulse_load(16'h0000, 4'b0000);
    run(70);
    lz_blank_en = 0;
    run_to(20);
    enable = 0;
    tick();
    check("disable_an", an, 4'hF);
    check("disable_bcd", digit_bcd, 4'hF);
    enable = 1;
    pulse_load(16'h1234, 4'b0001);
    run(70);
    repeat (400) begin
      enable      = $urandom_range(0, 19) != 0;
      load        = $urandom_range(0, 9) == 0;
      value_in    = 16'($urandom);
      dp_in       = 4'($urandom);
      lz_blank_en = 1'($urandom);
      tick();
    end
    load = 0;
    enable = 1;
    lz_blank_en = 0;
    run_to(5);
    #3 rst_n = 0;
    #1;
    model_reset();
    check("async_rst_an", an, 4'hF);
    check("async_rst_bcd", digit_bcd, 4'hF);
    check("async_rst_dp", dp_n, 1);
    check("async_rst_fd", frame_done, 0);
    run(2);
    rst_n = 1;
    enable = 0;
    run(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ss_scan_ctrl.md
Name: ss_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit common-anode seven-segment display.
- Holds a BCD display value and cycles one anode at a time.
- Presents each digit's BCD code to the shared combinational BCD-to-segment decoder.
- Inserts an anodes-off blanking gap between digits to suppress ghosting, applies optional leading-zero blanking, and double-buffers updates so a new value appears only at a frame boundary.

Parameters:
- NUM_DIGITS, 4: digits scanned; digit 0 is least significant, on an[0].
- REFRESH_DIV, 100000: clock cycles per digit slot (blank plus show); must be > BLANK_CYC.
- BLANK_CYC, 16: cycles per slot with all anodes off; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = scan; 0 = display dark
- load  in  1  single-cycle strobe; captures value_in and dp_in
- value_in  in  4*NUM_DIGITS  packed BCD; nibble i = digit i
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- lz_blank_en  in  1  leading-zero blanking enable
- an  out  NUM_DIGITS  anode selects, active-low, registered
- digit_bcd  out  4  BCD code to the decoder, registered; 4'hF = blank (decoder drives all segments off)
- dp_n  out  1  decimal-point segment, active-low, registered
- frame_done  out  1  one-cycle pulse at end of each full scan frame

Behaviour:
- Reset (async, rst_n=0): an all 1s, digit_bcd=4'hF, dp_n=1, frame_done=0, state IDLE, digit index 0, slot counter 0, active and shadow registers 0, pending=0.
- States:
  - IDLE: an all 1s, digit_bcd=4'hF, dp_n=1.
  - BLANK: an all 1s for BLANK_CYC cycles. digit_bcd and dp_n already carry the current digit's values, so the decoder settles before its anode turns on.
  - SHOW: an[idx]=0, all other anodes 1, for REFRESH_DIV-BLANK_CYC cycles.
- Transitions:
  - IDLE->BLANK (idx=0) on the first clock with enable=1.
  - BLANK->SHOW when the slot counter reaches BLANK_CYC-1.
  - SHOW->BLANK(idx+1) at slot end.
  - After the last digit (idx=NUM_DIGITS-1), SHOW->BLANK(idx=0); the next digit's idx wraps to 0.
- Frame end: on the cycle leaving SHOW of digit NUM_DIGITS-1:
  - frame_done=1 for exactly one cycle.
  - If pending=1: active<=shadow and pending<=0.
- enable=0 in any state: next cycle IDLE, idx and slot counter cleared, no frame_done. A pending update is applied on the IDLE-entry cycle.
- Load:
  - In IDLE, value_in and dp_in go directly into active.
  - Otherwise they go into shadow and pending<=1.
  - Repeated loads within one frame: the last one wins.
  - A load coincident with a frame end writes value_in straight to active and leaves pending=0, so the newer value beats the older shadow.
- Digit value presented:
  - Normally nibble idx of active.
  - Leading-zero blanking: when lz_blank_en=1, idx>0, and active nibbles idx..NUM_DIGITS-1 are all 0, digit_bcd=4'hF. Digit 0 is never blanked.
  - Non-BCD nibbles (A-F) pass through unchanged; the decoder blanks them.
- dp_n = ~active_dp[idx] in BLANK/SHOW, independent of zero blanking.
- Frame period is exactly NUM_DIGITS*REFRESH_DIV cycles. Any deasserted enable restarts the scan from digit 0.
- Outputs change only on clk edges. No combinational path from inputs to outputs.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
1. Reset values: assert rst_n=0 mid-SHOW (async, between edges) -> an=4'b1111, digit_bcd=4'hF, dp_n=1 immediately. After release with enable=0, outputs hold those values.
2. Basic scan: load value_in=16'h1234 in IDLE, then enable=1.
   - Digit 0: digit_bcd=4 with an=1111 for 2 cycles, then an=1110 for 6 cycles.
   - Digits 1-3 follow with codes 3, 2, 1.
   - frame_done pulses every 32 cycles.
3. Double buffer: while showing 16'h1234, load 16'h5678 during digit 1 -> remainder of the frame still shows 3, 2, 1. The next frame starts with digit_bcd=8.
4. Frame-end collision: load 16'h9999 mid-frame, then load 16'h4321 on the frame_done cycle -> next frame shows 1, 2, 3, 4 (16'h4321); 16'h9999 is never displayed.
5. Leading zeros: lz_blank_en=1, value 16'h0050 -> digits 3 and 2 get digit_bcd=4'hF, digit 1=5, digit 0=0. Value 16'h0000 -> only digit 0 shows 0.
6. Mid-frame disable: enable=0 during digit 2 SHOW -> next cycle an=1111, digit_bcd=F, no frame_done. Re-enable -> BLANK of digit 0; dp_in=4'b0001 gives dp_n=0 only in digit 0 slots.
